// File: rtl/ip1_test_pkg.sv
// Shared types and constants for the ip1 test sequencer and its pin mux.
package ip1_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    TMO   = 3'd5
  } seq_state_t;

  // config_load encoding on the chip pin
  localparam logic PARALLEL_OUT = 1'b1;
  localparam logic SHIFT_REG    = 1'b0;

  // Per-test pin bundle, MSB first: test k occupies test_pins[7k+6:7k]
  typedef struct packed {
    logic config_clk;
    logic reset_not;
    logic config_in;
    logic config_load;
    logic vin_test_trig_out;
    logic scan_in;
    logic scan_load;
  } pin_bundle_t;

  // Safe chip-pin levels whenever no test owns the pins
  localparam pin_bundle_t PIN_DEFAULTS = '{
    config_clk:        1'b0,
    reset_not:         1'b1,
    config_in:         1'b0,
    config_load:       PARALLEL_OUT,
    vin_test_trig_out: 1'b0,
    scan_in:           1'b0,
    scan_load:         1'b0
  };

  function automatic logic is_shift_mode(input pin_bundle_t b);
    return b.config_load == SHIFT_REG;
  endfunction

endpackage

// File: rtl/ip1_test_pin_mux.sv
// Combinational pin-bundle selector: picks bundle sel_i (1-based) from the
// packed per-test pin vector when granted, otherwise drives PIN_DEFAULTS.
module ip1_test_pin_mux
  import ip1_test_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 15
) (
  input  logic [7*NUM_TESTS-1:0] test_pins_i,
  input  logic [3:0]             sel_i,
  input  logic                   grant_i,
  output pin_bundle_t            pins_o
);

  // Index-driven select with default fallback for idle or out-of-range index
  always_comb begin
    pins_o = PIN_DEFAULTS;
    if (grant_i) begin
      for (int unsigned i = 0; i < NUM_TESTS; i++) begin
        if (sel_i == 4'(i + 1)) pins_o = test_pins_i[7*i +: 7];
      end
    end
  end

endmodule

// File: rtl/ip1_test_sequencer.sv
// ip1_test_sequencer: runs one selected test FSM at a time, owns the shared
// chip config/scan pins and reports busy/done/timeout/error status.
// Optional run-length timeout is built only when IP1_TEST_SEQ_TIMEOUT_EN is
// defined; otherwise sw_timeout is ignored and status_timeout is tied low.
module ip1_test_sequencer
  import ip1_test_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 15,
  parameter int unsigned TMO_W     = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             sw_test_sel,
  input  logic                   sw_start,
  input  logic                   sw_abort,
  input  logic [TMO_W-1:0]       sw_timeout,
  input  logic [NUM_TESTS-1:0]   test_done,
  input  logic [7*NUM_TESTS-1:0] test_pins,
  output logic [NUM_TESTS-1:0]   test_enable,
  output logic [NUM_TESTS-1:0]   test_start_re,
  output logic                   o_config_clk,
  output logic                   o_reset_not,
  output logic                   o_config_in,
  output logic                   o_config_load,
  output logic                   o_vin_test_trig_out,
  output logic                   o_scan_in,
  output logic                   o_scan_load,
  output logic [3:0]             active_sel,
  output logic [2:0]             seq_state,
  output logic                   status_busy,
  output logic                   status_done,
  output logic                   status_timeout,
  output logic                   status_err_sel
);

  seq_state_t           state_q;
  logic [3:0]           active_sel_q;
  logic                 sw_start_q;
  logic                 done_armed_q;
  logic                 status_done_q;
  logic                 status_err_sel_q;
  pin_bundle_t          pins_q;
  pin_bundle_t          pins_d;
  logic                 start_re;
  logic                 sel_bad;
  logic                 sel_done;
  logic                 busy;
  logic [NUM_TESTS-1:0] sel_onehot;

`ifdef IP1_TEST_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             status_timeout_q;
  logic             tmo_hit;
  assign tmo_hit        = (sw_timeout != '0) && (tmo_cnt_q == sw_timeout);
  assign status_timeout = status_timeout_q;
`else
  logic unused_sw_timeout;
  assign unused_sw_timeout = ^sw_timeout;
  assign status_timeout    = 1'b0;
`endif

  assign start_re = sw_start & ~sw_start_q;
  assign sel_bad  = (sw_test_sel == 4'd0) || (32'(sw_test_sel) > NUM_TESTS);
  assign busy     = (state_q == ARM) || (state_q == START) || (state_q == RUN);

  // Decode the latched index into a one-hot and pick that test's done flag
  always_comb begin
    sel_onehot = '0;
    sel_done   = 1'b0;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      if (active_sel_q == 4'(i + 1)) begin
        sel_onehot[i] = 1'b1;
        sel_done      = test_done[i];
      end
    end
  end

  ip1_test_pin_mux #(
    .NUM_TESTS (NUM_TESTS)
  ) u_pin_mux (
    .test_pins_i (test_pins),
    .sel_i       (active_sel_q),
    .grant_i     ((state_q == START) || (state_q == RUN)),
    .pins_o      (pins_d)
  );

  // Sequencer FSM, status flags, timeout counter and registered chip pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      active_sel_q     <= '0;
      sw_start_q       <= 1'b0;
      done_armed_q     <= 1'b0;
      status_done_q    <= 1'b0;
      status_err_sel_q <= 1'b0;
      pins_q           <= PIN_DEFAULTS;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
      tmo_cnt_q        <= '0;
      status_timeout_q <= 1'b0;
`endif
    end else begin
      sw_start_q <= sw_start;
      pins_q     <= pins_d;
      case (state_q)
        IDLE: begin
          if (start_re) begin
            status_done_q <= 1'b0;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
            status_timeout_q <= 1'b0;
`endif
            if (sel_bad) begin
              status_err_sel_q <= 1'b1;
            end else begin
              status_err_sel_q <= 1'b0;
              active_sel_q     <= sw_test_sel;
              done_armed_q     <= 1'b0;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
              tmo_cnt_q        <= '0;
`endif
              state_q          <= ARM;
            end
          end
        end
        ARM, START: begin
          if (sw_abort) begin
            state_q      <= IDLE;
            active_sel_q <= '0;
          end else begin
            state_q <= (state_q == ARM) ? START : RUN;
          end
        end
        RUN: begin
          // Ignore the sticky done from a previous run until it has been seen low
          if (!sel_done) done_armed_q <= 1'b1;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
          if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          // Priority: abort, then timeout, then done
          if (sw_abort) begin
            state_q      <= IDLE;
            active_sel_q <= '0;
          end
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= TMO;
          end
`endif
          else if (done_armed_q && sel_done) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          status_done_q <= 1'b1;
          state_q       <= IDLE;
          active_sel_q  <= '0;
        end
        TMO: begin
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
          status_timeout_q <= 1'b1;
`endif
          state_q      <= IDLE;
          active_sel_q <= '0;
        end
        default: begin
          state_q      <= IDLE;
          active_sel_q <= '0;
        end
      endcase
    end
  end

  assign test_enable   = busy ? sel_onehot : '0;
  assign test_start_re = (state_q == START) ? sel_onehot : '0;

  assign o_config_clk        = pins_q.config_clk;
  assign o_reset_not         = pins_q.reset_not;
  assign o_config_in         = pins_q.config_in;
  assign o_config_load       = pins_q.config_load;
  assign o_vin_test_trig_out = pins_q.vin_test_trig_out;
  assign o_scan_in           = pins_q.scan_in;
  assign o_scan_load         = pins_q.scan_load;

  assign active_sel     = active_sel_q;
  assign seq_state      = state_q;
  assign status_busy    = busy;
  assign status_done    = status_done_q;
  assign status_err_sel = status_err_sel_q;

endmodule

// File: tb/tb_ip1_test_sequencer.sv
// Directed self-checking bench for ip1_test_sequencer (NUM_TESTS=4).
module tb_ip1_test_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sw_test_sel;
  logic        sw_start;
  logic        sw_abort;
  logic [23:0] sw_timeout;
  logic [3:0]  test_done;
  logic [27:0] test_pins;
  logic [3:0]  test_enable;
  logic [3:0]  test_start_re;
  logic        o_config_clk, o_reset_not, o_config_in, o_config_load;
  logic        o_vin_test_trig_out, o_scan_in, o_scan_load;
  logic [3:0]  active_sel;
  logic [2:0]  seq_state;
  logic        status_busy, status_done, status_timeout, status_err_sel;
  logic [6:0]  pins_obs;
  logic [6:0]  bnd;
  logic [6:0]  prev;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] DEF = 7'b0101000;

  assign pins_obs = {o_config_clk, o_reset_not, o_config_in, o_config_load,
                     o_vin_test_trig_out, o_scan_in, o_scan_load};

  ip1_test_sequencer #(
    .NUM_TESTS (4),
    .TMO_W     (24)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .sw_test_sel         (sw_test_sel),
    .sw_start            (sw_start),
    .sw_abort            (sw_abort),
    .sw_timeout          (sw_timeout),
    .test_done           (test_done),
    .test_pins           (test_pins),
    .test_enable         (test_enable),
    .test_start_re       (test_start_re),
    .o_config_clk        (o_config_clk),
    .o_reset_not         (o_reset_not),
    .o_config_in         (o_config_in),
    .o_config_load       (o_config_load),
    .o_vin_test_trig_out (o_vin_test_trig_out),
    .o_scan_in           (o_scan_in),
    .o_scan_load         (o_scan_load),
    .active_sel          (active_sel),
    .seq_state           (seq_state),
    .status_busy         (status_busy),
    .status_done         (status_done),
    .status_timeout      (status_timeout),
    .status_err_sel      (status_err_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; sw_test_sel = '0; sw_start = 1'b0; sw_abort = 1'b0;
    sw_timeout = '0; test_done = '0; test_pins = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",  32'(seq_state), 32'd0);
    chk("rst_active", 32'(active_sel), 32'd0);
    chk("rst_en",     32'(test_enable), 32'd0);
    chk("rst_sre",    32'(test_start_re), 32'd0);
    chk("rst_status", 32'({status_busy, status_done, status_timeout, status_err_sel}), 32'd0);
    chk("rst_pins",   32'(pins_obs), 32'(DEF));
    reset = 1'b0;
    tick();

    // Normal run of test2, done 50 cycles after its start pulse
    sw_test_sel = 4'd2; sw_start = 1'b1;
    tick();
    chk("t1_arm_state", 32'(seq_state), 32'd1);
    chk("t1_arm_en",    32'(test_enable), 32'b0010);
    chk("t1_arm_sre",   32'(test_start_re), 32'd0);
    chk("t1_arm_busy",  32'(status_busy), 32'd1);
    chk("t1_arm_act",   32'(active_sel), 32'd2);
    tick();
    chk("t1_start_state", 32'(seq_state), 32'd2);
    chk("t1_start_sre",   32'(test_start_re), 32'b0010);
    chk("t1_start_en",    32'(test_enable), 32'b0010);
    tick();
    chk("t1_run_state", 32'(seq_state), 32'd3);
    chk("t1_run_sre",   32'(test_start_re), 32'd0);
    sw_start = 1'b0;
    tick();
    sw_start = 1'b1; sw_test_sel = 4'd1;
    tick();
    chk("t1_restart_ignored", 32'(seq_state), 32'd3);
    chk("t1_restart_act",     32'(active_sel), 32'd2);
    chk("t1_restart_sre",     32'(test_start_re), 32'd0);
    sw_start = 1'b0;
    repeat (46) tick();
    chk("t1_run_en",  32'(test_enable), 32'b0010);
    chk("t1_run_st2", 32'(seq_state), 32'd3);
    test_done[1] = 1'b1;
    tick();
    chk("t1_done_state", 32'(seq_state), 32'd4);
    chk("t1_done_en",    32'(test_enable), 32'd0);
    chk("t1_done_busy",  32'(status_busy), 32'd0);
    tick();
    chk("t1_idle_state", 32'(seq_state), 32'd0);
    chk("t1_status_done", 32'(status_done), 32'd1);
    chk("t1_idle_act",   32'(active_sel), 32'd0);

    // Stale sticky done on test1 must be ignored until seen low
    test_done[0] = 1'b1; sw_test_sel = 4'd1; sw_start = 1'b1;
    tick();
    chk("t2_arm_done_clr", 32'(status_done), 32'd0);
    tick();
    chk("t2_start_sre", 32'(test_start_re), 32'b0001);
    sw_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stale_run", 32'(seq_state), 32'd3);
    end
    test_done[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_wait_run", 32'(seq_state), 32'd3);
    end
    test_done[0] = 1'b1;
    tick();
    chk("t2_done_state", 32'(seq_state), 32'd4);
    tick();
    chk("t2_idle_state", 32'(seq_state), 32'd0);
    chk("t2_status_done", 32'(status_done), 32'd1);

    // Rejected selection 0
    sw_test_sel = 4'd0; sw_start = 1'b1;
    tick();
    chk("t3_err",      32'(status_err_sel), 32'd1);
    chk("t3_state",    32'(seq_state), 32'd0);
    chk("t3_en",       32'(test_enable), 32'd0);
    chk("t3_done_clr", 32'(status_done), 32'd0);
    sw_start = 1'b0;
    tick();

    // Timeout on test4 with done never arriving
    sw_test_sel = 4'd4; sw_timeout = 24'd100; test_pins[27:21] = 7'b1010111; sw_start = 1'b1;
    tick();
    chk("t4_err_clr", 32'(status_err_sel), 32'd0);
    chk("t4_arm",     32'(seq_state), 32'd1);
    sw_start = 1'b0;
    tick();
    tick();
    repeat (100) tick();
    chk("t4_run_last", 32'(seq_state), 32'd3);
    chk("t4_run_pins", 32'(pins_obs), 32'b1010111);
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
    tick();
    chk("t4_tmo_state", 32'(seq_state), 32'd5);
    chk("t4_tmo_pins",  32'(pins_obs), 32'b1010111);
    chk("t4_tmo_en",    32'(test_enable), 32'd0);
    tick();
    chk("t4_idle_state", 32'(seq_state), 32'd0);
    chk("t4_status_tmo", 32'(status_timeout), 32'd1);
    chk("t4_idle_pins",  32'(pins_obs), 32'(DEF));
    chk("t4_idle_act",   32'(active_sel), 32'd0);
`else
    tick();
    chk("t4_no_tmo_state", 32'(seq_state), 32'd3);
    chk("t4_no_tmo_flag",  32'(status_timeout), 32'd0);
    sw_abort = 1'b1;
    tick();
    chk("t4_abort_state", 32'(seq_state), 32'd0);
    sw_abort = 1'b0;
    tick();
    chk("t4_idle_pins", 32'(pins_obs), 32'(DEF));
`endif

    // Abort coinciding with done on test2
    sw_timeout = '0; test_done[1] = 1'b0; sw_test_sel = 4'd2; sw_start = 1'b1;
    tick();
    chk("t5_tmo_clr", 32'(status_timeout), 32'd0);
    sw_start = 1'b0;
    tick();
    tick();
    repeat (3) tick();
    test_done[1] = 1'b1; sw_abort = 1'b1;
    tick();
    chk("t5_state",  32'(seq_state), 32'd0);
    chk("t5_status", 32'({status_busy, status_done, status_timeout, status_err_sel}), 32'd0);
    chk("t5_act",    32'(active_sel), 32'd0);
    chk("t5_en",     32'(test_enable), 32'd0);
    sw_abort = 1'b0;
    tick();

    // Pin routing from test3
    test_pins[20:14] = 7'b0001111; sw_test_sel = 4'd3; sw_start = 1'b1;
    tick();
    chk("t6_arm_pins", 32'(pins_obs), 32'(DEF));
    chk("t6_arm_en",   32'(test_enable), 32'b0100);
    sw_start = 1'b0;
    tick();
    chk("t6_start_pins", 32'(pins_obs), 32'(DEF));
    chk("t6_start_sre",  32'(test_start_re), 32'b0100);
    tick();
    chk("t6_run_pins", 32'(pins_obs), 32'b0001111);
    prev = 7'b0001111;
    for (int i = 0; i < 6; i++) begin
      bnd = {i[0], 1'b0, i[1], 1'b0, 1'b0, 1'b0, ~i[0]};
      test_pins[20:14] = bnd;
      #1;
      chk("t6_lag_old", 32'(pins_obs), 32'(prev));
      tick();
      chk("t6_lag_new", 32'(pins_obs), 32'(bnd));
      prev = bnd;
    end
    sw_abort = 1'b1;
    tick();
    chk("t6_abort_state", 32'(seq_state), 32'd0);
    sw_abort = 1'b0;
    tick();
    chk("t6_idle_reset_not",   32'(o_reset_not), 32'd1);
    chk("t6_idle_config_load", 32'(o_config_load), 32'd1);
    chk("t6_idle_pins",        32'(pins_obs), 32'(DEF));

    // Asynchronous reset in the middle of a run of test1
    test_done[0] = 1'b0; test_pins[6:0] = 7'b1111111; sw_test_sel = 4'd1; sw_start = 1'b1;
    tick();
    sw_start = 1'b0;
    tick();
    tick();
    tick();
    chk("t7_run_pins", 32'(pins_obs), 32'b1111111);
    #3 reset = 1'b1;
    #1;
    chk("t7_rst_state", 32'(seq_state), 32'd0);
    chk("t7_rst_en",    32'(test_enable), 32'd0);
    chk("t7_rst_sre",   32'(test_start_re), 32'd0);
    chk("t7_rst_act",   32'(active_sel), 32'd0);
    chk("t7_rst_pins",  32'(pins_obs), 32'(DEF));
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Out-of-range selection 15 with four tests attached
    sw_test_sel = 4'd15; sw_start = 1'b1;
    tick();
    chk("t8_err",   32'(status_err_sel), 32'd1);
    chk("t8_state", 32'(seq_state), 32'd0);
    chk("t8_en",    32'(test_enable), 32'd0);
    sw_start = 1'b0;
    tick();
    chk("t8_still_idle", 32'(seq_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ip1_test_sequencer.md
# ip1_test_sequencer

Controller that sequences and shares the chip-facing configuration and scan pins among up to `NUM_TESTS` test state machines (test1..test15). Software selects one test and pulses start; the block enables only that test and issues its single-cycle start pulse. It routes that test's pin bundle to the chip pins, watches the test's done flag, and reports busy, done, timeout and error status back to the AXI register file.

## Interface
Parameters:
- `NUM_TESTS`, 15: number of attached test FSMs; legal range 1..15.
- `TMO_W`, 24: width of the timeout counter and of `sw_timeout`.

Ports:
- `clk` in 1: FM clock, 100 MHz, mapped to S_AXI_ACLK.
- `reset` in 1: asynchronous, active-high reset.
- `sw_test_sel` in 4: requested test index; 0 = none; legal values 1..`NUM_TESTS`.
- `sw_start` in 1: software start level; only its rising edge acts.
- `sw_abort` in 1: level; while high, any active run is cancelled.
- `sw_timeout` in `TMO_W`: run limit in clk cycles; 0 disables the limit.
- `test_done` in `NUM_TESTS`: per-test status_done flags; these are sticky inside each test.
- `test_pins` in `7*NUM_TESTS`: per-test pin bundle {config_clk, reset_not, config_in, config_load, vin_test_trig_out, scan_in, scan_load}; test k occupies bits [7k+6:7k] for k = 0..`NUM_TESTS`-1.
- `test_enable` out `NUM_TESTS`: one-hot enable for the test being sequenced.
- `test_start_re` out `NUM_TESTS`: one-hot, single-cycle start pulse.
- `o_config_clk`, `o_reset_not`, `o_config_in`, `o_config_load`, `o_vin_test_trig_out`, `o_scan_in`, `o_scan_load` out 1 each: chip pins.
- `active_sel` out 4: test index latched at start; 0 when idle.
- `seq_state` out 3: current FSM state.
- `status_busy`, `status_done`, `status_timeout`, `status_err_sel` out 1 each.

## Operation
- Rising-edge detect: `sw_start_d` is a register; `start_re = sw_start & ~sw_start_d`.
- States and transitions:
  - IDLE=0: on `start_re`:
    - If `sw_test_sel` is 0 or greater than `NUM_TESTS`: set `status_err_sel` and stay in IDLE.
    - Otherwise: latch `active_sel`, clear all status flags, clear `done_armed` and the timeout counter, and go to ARM.
  - ARM=1: `test_enable[active_sel-1]`=1; go to START. This gives the test one enabled cycle before it sees its start pulse.
  - START=2: enable held; `test_start_re[active_sel-1]`=1 for exactly this cycle; go to RUN.
  - RUN=3:
    - Enable held.
    - `done_armed` sets on the first cycle where the selected `test_done`=0. This masks the stale sticky done left over from a previous run.
    - If `done_armed` is set and the selected `test_done`=1, go to DONE.
  - DONE=4: set `status_done`, deassert enable, go to IDLE.
  - TMO=5: set `status_timeout`, deassert enable, go to IDLE.
- Abort: `sw_abort`=1 in ARM, START or RUN sends the FSM to IDLE next cycle. Enables drop, no status flag is set, and `active_sel` returns to 0.
- Simultaneous events in RUN: abort beats timeout, and timeout beats done.
- `start_re` outside IDLE is ignored; no queuing.
- `status_busy` = 1 in ARM, START and RUN.
- Status flags stay set until the next accepted or rejected `start_re`, or until reset.
- `test_enable` and `test_start_re` are decoded from registered state and `active_sel` only, so they are glitch-free.
- Pin mux:
  - In START and RUN, the chip pins take the selected bundle.
  - Otherwise they take the defaults: config_clk=0, reset_not=1, config_in=0, config_load=1 (PARALLEL_OUT), and trig/scan_in/scan_load=0.
- Reset values: state IDLE, `active_sel`=0, all enables and pulses 0, all status flags 0, pins at defaults, counter 0, `sw_start_d`=0.

## Timing
- `sw_start` rises at edge N: ARM is entered at N+1, START at N+2 (the pulse is high for one cycle), RUN at N+3.
- Chip pins are registered: 1 clk latency from `test_pins` to `o_*` while in START or RUN. Defaults return 1 clk after leaving RUN.
- Done: the selected `test_done` is high at edge M (with `done_armed` set); DONE is entered at M+1 and IDLE at M+2.
- Timeout counter:
  - Increments every RUN cycle; its width is `TMO_W` and it saturates at its maximum.
  - When the counter equals `sw_timeout` (nonzero), TMO is entered next cycle.
  - `sw_timeout` is sampled live.
- Reset asserted mid-run: all outputs reach their reset values asynchronously, with no glitch pulse on `test_start_re`.

## Configuration
- `IP1_TEST_SEQ_TIMEOUT_EN` defined: the timeout counter, the TMO state and `status_timeout` are implemented as described.
- Not defined: no counter logic; `sw_timeout` is ignored; `status_timeout` is tied 0; TMO is unreachable, and the state encoding stays the same.

## Structure
- The shared package `ip1_test_pkg` holds:
  - the `seq_state_t` enum (IDLE..TMO);
  - the `pin_bundle_t` packed struct (7 bits, order as above);
  - the `PIN_DEFAULTS` constant;
  - the `PARALLEL_OUT`/`SHIFT_REG` encoding.
- One natural sub-module: `ip1_test_pin_mux`, which selects a bundle by index from the packed `test_pins` and substitutes `PIN_DEFAULTS` when not granted. It is combinational; the parent registers its output.

## Test plan
- `sw_test_sel`=2, `sw_start` rising; stub test2 raises done 50 cycles after its start pulse:
  - `test_enable`=0b10 from N+1 until DONE;
  - one `test_start_re[1]` pulse at N+2;
  - `status_done`=1, and `active_sel` returns to 0.
- Stale done: `test_done[0]` is held 1 at start and drops 3 cycles after the pulse, then rises 10 cycles later → DONE only after that second rise.
- `sw_test_sel`=0, then 15 with `NUM_TESTS`=4 → `status_err_sel`=1, state stays IDLE, `test_enable`=0.
- `sw_timeout`=100 and done never arrives → TMO after 100 RUN cycles, `status_timeout`=1, pins back to defaults 1 cycle later.
- `sw_abort` in RUN on the same cycle as done → IDLE, all status flags 0.
- Pin routing: test3 drives config_clk toggling with reset_not=0 → the `o_*` pins follow with 1-cycle lag in RUN; in IDLE, `o_reset_not`=1 and `o_config_load`=1.
